// File: rtl/vol_ctrl_pkg.sv
// Shared types and constants for the volume step controller.
// VOL_AUTO_REPEAT_EN adds the RPT state used by the auto-repeat build.
package vol_ctrl_pkg;

  localparam int DB_CNT_DEF  = 500000;
  localparam int RPT_DLY_DEF = 25000000;
  localparam int RPT_PER_DEF = 5000000;

  // Wide enough for the largest default timing constant (25 bits).
  localparam int TMR_W = $clog2(RPT_DLY_DEF);

`ifdef VOL_AUTO_REPEAT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_HOLD  = 3'd2,
    ST_RPT   = 3'd3,
    ST_LOCK  = 3'd4
  } vol_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_HOLD  = 3'd2,
    ST_LOCK  = 3'd4
  } vol_state_e;
`endif

endpackage

// File: rtl/vol_step_ctrl_if.sv
// Button inputs and step-pulse outputs of the volume step controller.
interface vol_step_ctrl_if;
  logic btn_up_n;
  logic btn_dwn_n;
  logic step_up;
  logic step_dwn;

  modport master (output btn_up_n, output btn_dwn_n, input step_up, input step_dwn);
  modport slave  (input btn_up_n, input btn_dwn_n, output step_up, output step_dwn);
endinterface

// File: rtl/vol_step_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a stable-time debounce counter.
// Output is the active-low debounced level; it resets to released.
module btn_debounce
  import vol_ctrl_pkg::*;
#(
  parameter int DB_CNT = DB_CNT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic db_n
);

  localparam logic [TMR_W-1:0] DB_LAST = TMR_W'(DB_CNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // Any cycle where the synchronized level agrees with db_n restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      db_n <= 1'b1;
    end else if (sync_p1 == db_n) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt  <= '0;
      db_n <= sync_p1;
    end else begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/vol_step_ctrl.sv
// Volume up/down pushbutton controller producing registered one-cycle step pulses.
// Define VOL_AUTO_REPEAT_EN to enable hold-to-repeat (HOLD -> RPT).
module vol_step_ctrl
  import vol_ctrl_pkg::*;
#(
  parameter int DB_CNT  = DB_CNT_DEF,
  parameter int RPT_DLY = RPT_DLY_DEF,
  parameter int RPT_PER = RPT_PER_DEF
) (
  input logic            clk,
  input logic            rst_n,
  vol_step_ctrl_if.slave bus
);

  logic       up_db_n, dwn_db_n;
  logic       up_on, dwn_on, act_on, opp_on;
  vol_state_e state, state_nxt;
  logic       dir_dwn, dir_dwn_nxt;
  logic       fire, up_nxt, dwn_nxt;
  logic       step_up_q, step_dwn_q;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (bus.btn_up_n),
    .db_n  (up_db_n)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_dwn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (bus.btn_dwn_n),
    .db_n  (dwn_db_n)
  );

  assign up_on  = ~up_db_n;
  assign dwn_on = ~dwn_db_n;
  assign act_on = dir_dwn ? dwn_on : up_on;
  assign opp_on = dir_dwn ? up_on  : dwn_on;

`ifdef VOL_AUTO_REPEAT_EN
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(RPT_DLY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(RPT_PER - 1);

  logic [TMR_W-1:0] tmr, tmr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr <= '0;
    else        tmr <= tmr_nxt;
  end
`else
  // Repeat timing is unused in the single-pulse build.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = RPT_DLY[0] ^ RPT_PER[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dir_dwn    <= 1'b0;
      step_up_q  <= 1'b0;
      step_dwn_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir_dwn    <= dir_dwn_nxt;
      step_up_q  <= up_nxt;
      step_dwn_q <= dwn_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dir_dwn_nxt = dir_dwn;
`ifdef VOL_AUTO_REPEAT_EN
    tmr_nxt     = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (up_on && dwn_on) begin
          state_nxt = ST_LOCK;
        end else if (up_on || dwn_on) begin
          state_nxt   = ST_PRESS;
          dir_dwn_nxt = dwn_on;
        end
      end
      ST_PRESS: state_nxt = opp_on ? ST_LOCK : ST_HOLD;
      ST_HOLD: begin
        if (opp_on)       state_nxt = ST_LOCK;
        else if (!act_on) state_nxt = ST_IDLE;
`ifdef VOL_AUTO_REPEAT_EN
        else if (tmr == DLY_LAST) state_nxt = ST_RPT;
        else                      tmr_nxt   = tmr + TMR_W'(1);
`endif
      end
`ifdef VOL_AUTO_REPEAT_EN
      ST_RPT: begin
        if (opp_on)                state_nxt = ST_LOCK;
        else if (!act_on)          state_nxt = ST_IDLE;
        else if (tmr != PER_LAST)  tmr_nxt   = tmr + TMR_W'(1);
      end
`endif
      ST_LOCK:  if (!up_on && !dwn_on) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pulse decision is registered next cycle, so buttons never reach outputs combinationally.
  always_comb begin
    fire = 1'b0;
    unique case (state)
      ST_PRESS: fire = !opp_on;
`ifdef VOL_AUTO_REPEAT_EN
      ST_HOLD:  fire = act_on && !opp_on && (tmr == DLY_LAST);
      ST_RPT:   fire = act_on && !opp_on && (tmr == PER_LAST);
`endif
      default:  fire = 1'b0;
    endcase
    up_nxt  = fire && !dir_dwn;
    dwn_nxt = fire && dir_dwn;
  end

  assign bus.step_up  = step_up_q;
  assign bus.step_dwn = step_dwn_q;

endmodule

// File: tb/tb_vol_step_ctrl.sv
// Directed bench for vol_step_ctrl with short debounce/repeat timing.
module tb_vol_step_ctrl;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
  localparam int LAT = DB + 4;
`ifdef VOL_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vol_step_ctrl_if bus ();

  vol_step_ctrl #(.DB_CNT(DB), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    up;
    bit    dn;
    int    hold;
    int    exp_up;
    int    exp_dn;
    int    exp_first;
    int    exp_last;
  } vec_t;

  vec_t vecs [7];

  int   cyc = 0;
  int   up_q [$];
  int   dn_q [$];
  int   viol = 0;
  logic prev_up = 1'b0;
  logic prev_dn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   t0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.step_up)  up_q.push_back(cyc);
      if (bus.step_dwn) dn_q.push_back(cyc);
      if ((bus.step_up && bus.step_dwn) || (bus.step_up && prev_up) || (bus.step_dwn && prev_dn))
        viol <= viol + 1;
    end
    prev_up <= bus.step_up;
    prev_dn <= bus.step_dwn;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int first_off(input int q [$], input int base);
    if (q.size() == 0) return -1;
    return q[0] - base;
  endfunction

  function automatic int last_off(input int q [$], input int base);
    if (q.size() == 0) return -1;
    return q[q.size()-1] - base;
  endfunction

  task automatic clear_log();
    up_q.delete();
    dn_q.delete();
    t0 = cyc;
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    @(negedge clk);
    clear_log();
    bus.btn_up_n  = !up;
    bus.btn_dwn_n = !dn;
    repeat (hold) @(negedge clk);
    bus.btn_up_n  = 1'b1;
    bus.btn_dwn_n = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_up_n  = 1'b1;
    bus.btn_dwn_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_step_up", bus.step_up, 0);
    check("reset_step_dwn", bus.step_dwn, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    vecs[0] = '{"up_hold30", 1'b1, 1'b0, 30, AUTO ? 3 : 1, 0, LAT, AUTO ? LAT + 28 : LAT};
    vecs[1] = '{"dn_hold30", 1'b0, 1'b1, 30, 0, AUTO ? 3 : 1, LAT, AUTO ? LAT + 28 : LAT};
    vecs[2] = '{"up_hold3_short", 1'b1, 1'b0, 3, 0, 0, -1, -1};
    vecs[3] = '{"up_hold4_min", 1'b1, 1'b0, 4, 1, 0, LAT, LAT};
    vecs[4] = '{"up_hold21", 1'b1, 1'b0, 21, 1, 0, LAT, LAT};
    vecs[5] = '{"up_hold22", 1'b1, 1'b0, 22, AUTO ? 2 : 1, 0, LAT, AUTO ? LAT + 20 : LAT};
    vecs[6] = '{"both_hold30", 1'b1, 1'b1, 30, 0, 0, -1, -1};

    for (int i = 0; i < 7; i++) begin
      press(vecs[i].up, vecs[i].dn, vecs[i].hold);
      check({vecs[i].name, "_up_cnt"}, up_q.size(), vecs[i].exp_up);
      check({vecs[i].name, "_dn_cnt"}, dn_q.size(), vecs[i].exp_dn);
      if (vecs[i].exp_up > 0) begin
        check({vecs[i].name, "_up_first"}, first_off(up_q, t0), vecs[i].exp_first);
        check({vecs[i].name, "_up_last"}, last_off(up_q, t0), vecs[i].exp_last);
      end
      if (vecs[i].exp_dn > 0) begin
        check({vecs[i].name, "_dn_first"}, first_off(dn_q, t0), vecs[i].exp_first);
        check({vecs[i].name, "_dn_last"}, last_off(dn_q, t0), vecs[i].exp_last);
      end
    end

    // Bouncing down button, then stable low
    @(negedge clk);
    clear_log();
    repeat (3) begin
      bus.btn_dwn_n = 1'b0;
      repeat (2) @(negedge clk);
      bus.btn_dwn_n = 1'b1;
      @(negedge clk);
    end
    bus.btn_dwn_n = 1'b0;
    t0 = cyc;
    repeat (12) @(negedge clk);
    bus.btn_dwn_n = 1'b1;
    repeat (25) @(negedge clk);
    check("bounce_dn_cnt", dn_q.size(), 1);
    check("bounce_dn_first", first_off(dn_q, t0), LAT);
    check("bounce_up_cnt", up_q.size(), 0);

    // Both pressed, release up only, release both, then press up
    @(negedge clk);
    clear_log();
    bus.btn_up_n  = 1'b0;
    bus.btn_dwn_n = 1'b0;
    repeat (15) @(negedge clk);
    bus.btn_up_n = 1'b1;
    repeat (15) @(negedge clk);
    check("lock_up_rel_up_cnt", up_q.size(), 0);
    check("lock_up_rel_dn_cnt", dn_q.size(), 0);
    bus.btn_dwn_n = 1'b1;
    repeat (25) @(negedge clk);
    check("lock_all_rel_up_cnt", up_q.size(), 0);
    check("lock_all_rel_dn_cnt", dn_q.size(), 0);
    press(1'b1, 1'b0, 12);
    check("after_lock_up_cnt", up_q.size(), 1);
    check("after_lock_up_first", first_off(up_q, t0), LAT);
    check("after_lock_dn_cnt", dn_q.size(), 0);

    // Hold down past the first repeat, then add up
    @(negedge clk);
    clear_log();
    bus.btn_dwn_n = 1'b0;
    repeat (LAT + DLY + 1) @(negedge clk);
    bus.btn_up_n = 1'b0;
    repeat (30) @(negedge clk);
    bus.btn_up_n  = 1'b1;
    bus.btn_dwn_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rpt_lock_dn_cnt", dn_q.size(), AUTO ? 2 : 1);
    check("rpt_lock_dn_last", last_off(dn_q, t0), AUTO ? LAT + DLY : LAT);
    check("rpt_lock_up_cnt", up_q.size(), 0);

    // Asynchronous reset while holding up, then a fresh debounce
    @(negedge clk);
    clear_log();
    bus.btn_up_n = 1'b0;
    repeat (LAT) @(negedge clk);
    check("pre_reset_pulse", bus.step_up, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_step_up", bus.step_up, 0);
    check("async_reset_step_dwn", bus.step_dwn, 0);
    repeat (3) @(negedge clk);
    check("in_reset_step_up", bus.step_up, 0);
    rst_n = 1'b1;
    clear_log();
    repeat (12) @(negedge clk);
    bus.btn_up_n = 1'b1;
    repeat (25) @(negedge clk);
    check("post_reset_up_cnt", up_q.size(), 1);
    check("post_reset_up_first", first_off(up_q, t0), LAT);
    check("post_reset_dn_cnt", dn_q.size(), 0);

    check("overlap_or_back_to_back", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vol_step_ctrl.md
VOL_STEP_CTRL -- requirements
Module: vol_step_ctrl

Interface
REQ-001 SHALL have parameter DB_CNT, default 500000, debounce stable-time in clk cycles (10 ms at 50 MHz).
REQ-002 SHALL have parameter RPT_DLY, default 25000000, hold time before first auto-repeat (500 ms).
REQ-003 SHALL have parameter RPT_PER, default 5000000, auto-repeat period (100 ms).
REQ-004 SHALL have port clk, input, 1, 50 MHz clock.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_up_n, input, 1, raw active-low volume-up pushbutton, asynchronous to clk.
REQ-007 SHALL have port btn_dwn_n, input, 1, raw active-low volume-down pushbutton, asynchronous to clk.
REQ-008 SHALL have port step_up, output, 1, one-cycle pulse requesting volume increment.
REQ-009 SHALL have port step_dwn, output, 1, one-cycle pulse requesting volume decrement.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL debounce each synchronized input: the debounced level changes only after the synchronized level differs from it for DB_CNT consecutive cycles; any bounce restarts the count at 0.
REQ-012 SHALL run FSM states IDLE, PRESS, HOLD, RPT, LOCK.
REQ-013 IDLE: exactly one debounced button pressed -> PRESS, with that button latched as the active direction; both pressed -> LOCK.
REQ-014 PRESS: SHALL assert the active step output for exactly one cycle, clear the hold timer, go to HOLD.
REQ-015 HOLD: active button released -> IDLE; timer reaches RPT_DLY-1 -> RPT, emitting one step pulse and clearing the timer.
REQ-016 RPT: one step pulse each time the timer reaches RPT_PER-1 (timer then clears); active button released -> IDLE with no further pulse.
REQ-017 In PRESS, HOLD or RPT, the opposite button becoming debounced-pressed -> LOCK with no pulse that cycle.
REQ-018 LOCK: no pulses; -> IDLE only when both debounced buttons are released.
REQ-019 step_up and step_dwn SHALL never be asserted in the same cycle, and never for two consecutive cycles.
REQ-020 Latency: first step pulse SHALL assert exactly 2 cycles after the debounced level goes pressed (IDLE->PRESS, then pulse registered).
REQ-021 Timers SHALL saturate-free count to 25 bits, sized from the largest parameter; parameters below 2 are illegal.

Reset
REQ-022 On rst_n low: FSM=IDLE, synchronizers and debounced levels=released (1), counters=0, step_up=0, step_dwn=0.
REQ-023 Reset during a hold or repeat SHALL abort without a pulse; after release a still-held button is debounced anew (DB_CNT cycles) before any pulse.

Configuration
REQ-024 Macro VOL_AUTO_REPEAT_EN defined: HOLD/RPT behaviour per REQ-015/016.
REQ-025 Macro VOL_AUTO_REPEAT_EN undefined: HOLD holds until release with no further pulses; RPT state and repeat timer SHALL be absent; one pulse per press.

Structure
REQ-026 Package vol_ctrl_pkg SHALL hold the FSM state enum, default DB/RPT constants and the 25-bit timer width.
REQ-027 Sub-module btn_debounce (synchronizer + debounce counter, parameter DB_CNT) SHALL be instantiated once per button.
REQ-028 Step outputs SHALL be registered; no combinational path from buttons to outputs.

Verification (DB_CNT=4, RPT_DLY=20, RPT_PER=8)
REQ-029 btn_up_n low held 30 cycles, VOL_AUTO_REPEAT_EN on -> one step_up pulse, then repeat pulses 20 and 28 cycles after the first; step_dwn never asserts.
REQ-030 btn_dwn_n bouncing (low 2, high 1, low 2, ...) then stable low -> exactly one step_dwn pulse, DB_CNT+2+2 cycles after the stable-low edge.
REQ-031 Both buttons pressed together -> no pulses; release up only -> still none; release both, then press up -> one step_up.
REQ-032 Hold dwn until the first repeat, press up -> no further pulses until both released.
REQ-033 rst_n asserted mid-HOLD with up held -> outputs 0 immediately; after deassert, the first step_up appears after a fresh debounce.
REQ-034 VOL_AUTO_REPEAT_EN undefined, up held 100 cycles -> exactly one step_up pulse.
